// File: rtl/hamming_pkg.sv
// Shared constants and elaboration-time helpers for the SECDED Hamming codec family.
package hamming_pkg;

    localparam logic [1:0] ST_CLEAN   = 2'b00;
    localparam logic [1:0] ST_CORR    = 2'b01;
    localparam logic [1:0] ST_DED     = 2'b10;
    localparam logic [1:0] ST_INVALID = 2'b11;

    // Smallest r with 2^r >= data_w + r + 1.
    function automatic int calc_par_w(input int data_w);
        for (int r = 1; r < 16; r++) begin
            if ((1 << r) >= data_w + r + 1) return r;
        end
        return 16;
    endfunction

    function automatic bit is_pow2(input int p);
        return (p != 0) && ((p & (p - 1)) == 0);
    endfunction

    // Hamming position holding data bit idx; data fills non-power-of-2 slots from position 3 up.
    function automatic int data_pos(input int idx);
        int n;
        n = 0;
        for (int p = 3; p < 512; p++) begin
            if (!is_pow2(p)) begin
                if (n == idx) return p;
                n++;
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator, shared with the encoder.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 16,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [PAR_W-1:0]  syn_o,
    output logic              par_o
);

    // Syndrome bit k covers every position whose index has bit k set; position 0 never participates.
    for (genvar k = 0; k < PAR_W; k++) begin : g_syn
        logic [CODE_W-1:0] sel;
        for (genvar p = 0; p < CODE_W; p++) begin : g_pos
            if ((p != 0) && (((p >> k) & 1) == 1)) begin : g_on
                assign sel[p] = code_i[p];
            end else begin : g_off
                assign sel[p] = 1'b0;
            end
        end
        assign syn_o[k] = ^sel;
    end

    assign par_o = ^code_i;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED decoder with valid/ready flow control and saturating error counters.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              cfg_correct_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_status,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam int               N     = DATA_W + PAR_W;
    localparam logic [PAR_W-1:0] N_SYN = PAR_W'(N);

    logic [PAR_W-1:0] syn;
    logic             par;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syn (
        .code_i (in_code),
        .syn_o  (syn),
        .par_o  (par)
    );

    logic              s1_vld_q, s1_vld_d;
    logic [CODE_W-1:0] s1_code_q, s1_code_d;
    logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;
    logic              s1_cen_q, s1_cen_d;
    logic              s2_vld_q, s2_vld_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic [1:0]        s2_status_q, s2_status_d;
    logic [CNT_W-1:0]  corr_q, corr_d;
    logic [CNT_W-1:0]  uncorr_q, uncorr_d;

    logic              s2_adv;
    logic              out_hs;
    logic [1:0]        status;
    logic              flip;
    logic [CODE_W-1:0] fix_code;
    logic [DATA_W-1:0] ext_data;

    assign s2_adv   = !s2_vld_q || out_ready;
    assign in_ready = !s1_vld_q || s2_adv;
    assign out_hs   = s2_vld_q && out_ready;

    always_comb begin
        status = ST_CLEAN;
        flip   = 1'b0;
        if (s1_syn_q == '0) begin
            status = s1_par_q ? ST_CORR : ST_CLEAN;
        end else if (!s1_par_q) begin
            status = ST_DED;
        end else if (s1_syn_q <= N_SYN) begin
            status = ST_CORR;
            flip   = s1_cen_q;
        end else begin
            status = ST_INVALID;
        end
    end

    // A flip at a check position is harmless: extraction never reads those bits.
    assign fix_code = flip ? (s1_code_q ^ (CODE_W'(1) << s1_syn_q)) : s1_code_q;

    for (genvar i = 0; i < DATA_W; i++) begin : g_ext
        assign ext_data[i] = fix_code[data_pos(i)];
    end

    always_comb begin
        s1_vld_d    = s1_vld_q;
        s1_code_d   = s1_code_q;
        s1_syn_d    = s1_syn_q;
        s1_par_d    = s1_par_q;
        s1_cen_d    = s1_cen_q;
        s2_vld_d    = s2_vld_q;
        s2_data_d   = s2_data_q;
        s2_status_d = s2_status_q;
        corr_d      = corr_q;
        uncorr_d    = uncorr_q;

        if (in_ready) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_code_d = in_code;
                s1_syn_d  = syn;
                s1_par_d  = par;
                s1_cen_d  = cfg_correct_en;
            end
        end

        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_data_d   = ext_data;
                s2_status_d = status;
            end
        end

        // Clear takes priority; an increment in the same cycle is dropped.
        if (cnt_clr) begin
            corr_d   = '0;
            uncorr_d = '0;
        end else if (out_hs) begin
            if (s2_status_q == ST_CORR && corr_q != '1)
                corr_d = corr_q + CNT_W'(1);
            if (s2_status_q[1] && uncorr_q != '1)
                uncorr_d = uncorr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s1_code_q   <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            s1_cen_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_data_q   <= '0;
            s2_status_q <= ST_CLEAN;
            corr_q      <= '0;
            uncorr_q    <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_code_q   <= s1_code_d;
            s1_syn_q    <= s1_syn_d;
            s1_par_q    <= s1_par_d;
            s1_cen_q    <= s1_cen_d;
            s2_vld_q    <= s2_vld_d;
            s2_data_q   <= s2_data_d;
            s2_status_q <= s2_status_d;
            corr_q      <= corr_d;
            uncorr_q    <= uncorr_d;
        end
    end

    assign out_valid  = s2_vld_q;
    assign out_data   = s2_data_q;
    assign out_status = s2_status_q;
    assign corr_cnt   = corr_q;
    assign uncorr_cnt = uncorr_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for the SECDED decoder: main instance at CNT_W=16, second at CNT_W=4 for saturation.
module tb_hamming_secded_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 0, cfg_correct_en = 1, out_ready = 1, cnt_clr = 0;
    logic [21:0] in_code = '0;
    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_status;
    logic [15:0] corr_cnt, uncorr_cnt;

    logic        in_valid_b = 0, out_ready_b = 1, cnt_clr_b = 0;
    logic [21:0] in_code_b = '0;
    logic        in_ready_b, out_valid_b;
    logic [15:0] out_data_b;
    logic [1:0]  out_status_b;
    logic [3:0]  corr_b, uncorr_b;

    hamming_secded_decoder #(.DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .cfg_correct_en(cfg_correct_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_status(out_status), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    hamming_secded_decoder #(.DATA_W(16), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_code(in_code_b),
        .cfg_correct_en(1'b1), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_status(out_status_b), .cnt_clr(cnt_clr_b),
        .corr_cnt(corr_b), .uncorr_cnt(uncorr_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder: data into non-power-of-2 slots, even check bits, overall parity at bit 0.
    function automatic logic [21:0] enc(input logic [15:0] d);
        logic [21:0] c;
        int j;
        logic x;
        c = '0;
        j = 0;
        for (int p = 1; p <= 21; p++)
            if ((p & (p - 1)) != 0) begin c[p] = d[j]; j++; end
        for (int k = 0; k < 5; k++) begin
            x = 1'b0;
            for (int p = 1; p <= 21; p++)
                if (((p >> k) & 1) == 1 && p != (1 << k)) x ^= c[p];
            c[1 << k] = x;
        end
        c[0] = ^c[21:1];
        return c;
    endfunction

    // Entered and left at posedge+1; returns just after the accepting edge.
    task automatic send(input logic [21:0] code, input logic cen);
        logic ok, rdy;
        ok = 1'b0;
        in_code = code;
        cfg_correct_en = cen;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1 rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic expect_word(input string tag, input logic [15:0] d, input logic [1:0] st);
        chk({tag, "_not_early"}, out_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_status"}, out_status, st);
        @(posedge clk); #1;
    endtask

    logic [15:0] w [6];
    logic [21:0] c0;

    initial begin
        c0 = enc(16'hA5C3);
        for (int i = 0; i < 6; i++) w[i] = 16'h3C00 + 16'(i * 16'h0111);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_status", out_status, 0);
        chk("rst_corr", corr_cnt, 0);
        chk("rst_uncorr", uncorr_cnt, 0);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        send(c0, 1'b1);
        expect_word("clean", 16'hA5C3, 2'b00);
        chk("clean_corr", corr_cnt, 0);
        chk("clean_uncorr", uncorr_cnt, 0);

        send(c0 ^ 22'h000008, 1'b1);
        expect_word("sec_d0", 16'hA5C3, 2'b01);
        chk("sec_d0_corr", corr_cnt, 1);

        send(c0 ^ 22'h000008, 1'b0);
        expect_word("detonly", 16'hA5C2, 2'b01);
        chk("detonly_corr", corr_cnt, 2);

        send(c0 ^ 22'h001020, 1'b1);
        expect_word("ded", 16'hA541, 2'b10);
        chk("ded_uncorr", uncorr_cnt, 1);

        send(c0 ^ 22'h000001, 1'b1);
        expect_word("p0", 16'hA5C3, 2'b01);
        chk("p0_corr", corr_cnt, 3);

        send(c0 ^ 22'h010014, 1'b1);
        expect_word("invalid", 16'hA5C3, 2'b11);
        chk("invalid_uncorr", uncorr_cnt, 2);

        send(c0 ^ 22'h000100, 1'b1);
        expect_word("chkbit", 16'hA5C3, 2'b01);
        chk("chkbit_corr", corr_cnt, 4);

        // Backpressure stream: out_ready low on loop cycles 2..7.
        begin
            int sent, rcv, cyc;
            logic held_v, acc, emit;
            logic [15:0] held_d;
            sent = 0; rcv = 0; cyc = 0; held_v = 1'b0; held_d = '0;
            cfg_correct_en = 1'b1;
            while (rcv < 6 && cyc < 60) begin
                out_ready = !(cyc >= 2 && cyc <= 7);
                in_valid = (sent < 6);
                in_code = enc(w[(sent < 6) ? sent : 0]);
                #1;
                if (held_v) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, held_d);
                end
                if (!out_ready && (sent - rcv) == 2) chk("inready_full", in_ready, 0);
                acc = in_valid && in_ready;
                emit = out_valid && out_ready;
                if (emit) begin
                    chk("stream_data", out_data, w[rcv]);
                    rcv++;
                end
                held_v = out_valid && !out_ready;
                held_d = out_data;
                @(posedge clk); #1;
                if (acc) sent++;
                cyc++;
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            chk("stream_recv", rcv, 6);
            chk("stream_sent", sent, 6);
        end

        // Saturation on the 4-bit counter instance.
        begin
            int acc_n, cyc;
            acc_n = 0; cyc = 0;
            in_code_b = enc(16'h0F0F) ^ 22'h000080;
            while (acc_n < 20 && cyc < 60) begin
                in_valid_b = 1'b1;
                #1 if (in_ready_b) acc_n++;
                @(posedge clk); #1;
                cyc++;
            end
            in_valid_b = 1'b0;
            chk("sat_accepts", acc_n, 20);
            repeat (3) @(posedge clk);
            #1;
            chk("sat_corr", corr_b, 15);
            chk("sat_uncorr", uncorr_b, 0);
            in_valid_b = 1'b1;
            @(posedge clk); #1;
            in_valid_b = 1'b0;
            @(posedge clk); #1;
            chk("clr_hs_valid", out_valid_b, 1);
            chk("clr_hs_status", out_status_b, 2'b01);
            cnt_clr_b = 1'b1;
            @(posedge clk); #1;
            cnt_clr_b = 1'b0;
            chk("clr_corr", corr_b, 0);
            chk("clr_drained", out_valid_b, 0);
        end

        // Reset with two words in flight.
        begin
            logic ghost;
            out_ready = 1'b0;
            send(enc(w[0]), 1'b1);
            send(enc(w[1]), 1'b1);
            chk("prerst_valid", out_valid, 1);
            rst_n = 1'b0;
            #1;
            chk("midrst_valid", out_valid, 0);
            chk("midrst_data", out_data, 0);
            chk("midrst_corr", corr_cnt, 0);
            chk("midrst_uncorr", uncorr_cnt, 0);
            @(posedge clk);
            @(posedge clk); #1;
            rst_n = 1'b1;
            out_ready = 1'b1;
            #1 chk("postrst_in_ready", in_ready, 1);
            ghost = 1'b0;
            repeat (4) begin
                @(posedge clk); #1;
                if (out_valid) ghost = 1'b1;
            end
            chk("postrst_no_ghost", ghost, 0);
            send(enc(16'hBEEF), 1'b1);
            expect_word("postrst", 16'hBEEF, 2'b00);
            chk("postrst_corr", corr_cnt, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
